// File: rtl/alu_mc.sv
// alu_mc: request/response ALU with a single-cycle path and a multi-cycle
// path. MULU, DIVU and REMU iterate one bit per clock over WIDTH cycles.
// The result registers F, Cout and Zero hold their value until the next
// result is written. A handshake on each side controls the flow of requests.
module alu_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic [4:0]       Card,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] F,
   output logic             Cout,
   output logic             Zero
);

   localparam int            CW        = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
   localparam logic [4:0]    OP_MULU   = 5'd16;
   localparam logic [4:0]    OP_DIVU   = 5'd17;
   localparam logic [4:0]    OP_REMU   = 5'd18;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   // operands captured at accept for the iterative operations
   logic [WIDTH-1:0]     a_q, b_q;
   logic [4:0]           card_q;

   // iterative datapath: product register, quotient and partial remainder
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [WIDTH-1:0]     quo_q, quo_d;
   logic [WIDTH-1:0]     rem_q, rem_d;

   // result registers
   logic [WIDTH-1:0]     f_q;
   logic                 cout_q, zero_q;

   logic                 accept;
   logic                 is_multi;
   logic                 res_we;
   logic [WIDTH-1:0]     res_f;
   logic                 res_c;

   // single-cycle datapath
   logic [WIDTH-1:0]     add_x, add_y;
   logic                 add_ci;
   logic [WIDTH:0]       add_sum;
   logic [WIDTH-1:0]     alu_f;
   logic                 alu_c;

   // one step of each iterative algorithm
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   prod_step;
   logic [WIDTH:0]       div_shift;
   logic                 div_ge;
   logic [WIDTH-1:0]     div_diff;
   logic [WIDTH-1:0]     rem_step;
   logic [WIDTH-1:0]     quo_step;

   assign accept   = in_valid & in_ready;
   assign is_multi = (Card == OP_MULU) || (Card == OP_DIVU) || (Card == OP_REMU);

   // Select adder operands. All add/subtract cards share one WIDTH+1 bit adder.
   // X - Y - c is computed as X + ~Y + !c, so a carry out of 1 means no borrow.
   always_comb begin
      add_x  = A;
      add_y  = B;
      add_ci = 1'b0;
      case (Card)
         5'd2: add_ci = Cin;
         5'd3: begin add_y = ~B; add_ci = 1'b1; end
         5'd4: begin add_y = ~B; add_ci = ~Cin; end
         5'd5: begin add_x = B;  add_y = ~A; add_ci = 1'b1; end
         5'd6: begin add_x = B;  add_y = ~A; add_ci = ~Cin; end
         default: ;
      endcase
   end

   assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};

   // Compute the single-cycle result; undefined cards give zero with no flag.
   always_comb begin
      alu_f = '0;
      alu_c = 1'b0;
      case (Card)
         5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6: begin
            alu_f = add_sum[WIDTH-1:0];
            alu_c = add_sum[WIDTH];
         end
         5'd7:  alu_f = A;
         5'd8:  alu_f = B;
         5'd9:  alu_f = ~A;
         5'd10: alu_f = ~B;
         5'd11: alu_f = A | B;
         5'd12: alu_f = A & B;
         5'd13: alu_f = ~(A ^ B);
         5'd14: alu_f = A ^ B;
         5'd15: alu_f = ~(A & B);
         default: ;
      endcase
   end

   // Shift-add multiply: add A into the upper half when the current LSB of
   // the multiplier is 1, then shift the whole product right by one.
   assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
   assign prod_step = {mul_sum, prod_q[WIDTH-1:1]};

   // Restoring divide: shift the next dividend bit into the partial remainder.
   // Subtract only when the shifted value is at least the divisor. The
   // difference always fits in WIDTH bits.
   assign div_shift = {rem_q, quo_q[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, b_q});
   assign div_diff  = div_shift[WIDTH-1:0] - b_q;
   assign rem_step  = div_ge ? div_diff : div_shift[WIDTH-1:0];
   assign quo_step  = {quo_q[WIDTH-2:0], div_ge};

   // Next-state, iteration control, result selection and handshake outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      prod_d    = prod_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      res_we    = 1'b0;
      res_f     = '0;
      res_c     = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (is_multi) begin
                  state_d = BUSY;
                  cnt_d   = '0;
                  prod_d  = {{WIDTH{1'b0}}, B};
                  quo_d   = A;
                  rem_d   = '0;
               end else begin
                  state_d = DONE;
                  res_we  = 1'b1;
                  res_f   = alu_f;
                  res_c   = alu_c;
               end
            end
         end
         BUSY: begin
            prod_d = prod_step;
            quo_d  = quo_step;
            rem_d  = rem_step;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
               state_d = DONE;
               cnt_d   = '0;
               res_we  = 1'b1;
               case (card_q)
                  OP_MULU: begin
                     res_f = prod_step[WIDTH-1:0];
                     res_c = |prod_step[2*WIDTH-1:WIDTH];
                  end
                  OP_DIVU: begin
                     res_f = (b_q == '0) ? '1 : quo_step;
                     res_c = (b_q == '0);
                  end
                  OP_REMU: begin
                     res_f = (b_q == '0) ? a_q : rem_step;
                     res_c = (b_q == '0);
                  end
                  default: ;
               endcase
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state and iteration counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Capture the request operands on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         card_q <= '0;
      end else if (accept) begin
         a_q    <= A;
         b_q    <= B;
         card_q <= Card;
      end
   end

   // Iterative multiply/divide working registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
      end else begin
         prod_q <= prod_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
      end
   end

   // Result registers. Zero is derived from the WIDTH-bit value being stored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_q    <= '0;
         cout_q <= 1'b0;
         zero_q <= 1'b0;
      end else if (res_we) begin
         f_q    <= res_f;
         cout_q <= res_c;
         zero_q <= (res_f == '0);
      end
   end

   assign F    = f_q;
   assign Cout = cout_q;
   assign Zero = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH = 32.
module tb_alu_mc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        Cin = 1'b0;
   logic [4:0]  Card = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] F;
   logic        Cout;
   logic        Zero;

   int errors = 0;
   int checks = 0;

   // results of the last run_op call
   logic [31:0] r_f;
   logic        r_c, r_z, r_ok;
   int          r_lat;

   typedef struct {
      logic [4:0]  card;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] f;
      logic        c;
      logic        z;
      int          lat;
   } vec_t;

   vec_t arith_v [8] = '{
      '{5'd1, 32'h10,       32'h08,       1'b1, 32'h18,       1'b0, 1'b0, 1},
      '{5'd2, 32'h10,       32'h08,       1'b1, 32'h19,       1'b0, 1'b0, 1},
      '{5'd2, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        1'b1, 1'b1, 1},
      '{5'd3, 32'h8,        32'h10,       1'b0, 32'hFFFFFFF8, 1'b0, 1'b0, 1},
      '{5'd4, 32'h20,       32'h10,       1'b1, 32'h0F,       1'b1, 1'b0, 1},
      '{5'd5, 32'h10,       32'h30,       1'b0, 32'h20,       1'b1, 1'b0, 1},
      '{5'd6, 32'h10,       32'h30,       1'b1, 32'h1F,       1'b1, 1'b0, 1},
      '{5'd3, 32'h5,        32'h5,        1'b1, 32'h0,        1'b1, 1'b1, 1}
   };

   vec_t logic_v [9] = '{
      '{5'd7,  32'hF0F01234, 32'h0FF0FF00, 1'b1, 32'hF0F01234, 1'b0, 1'b0, 1},
      '{5'd8,  32'hF0F01234, 32'h0FF0FF00, 1'b1, 32'h0FF0FF00, 1'b0, 1'b0, 1},
      '{5'd9,  32'hF0F01234, 32'h0FF0FF00, 1'b1, 32'h0F0FEDCB, 1'b0, 1'b0, 1},
      '{5'd10, 32'hF0F01234, 32'h0FF0FF00, 1'b1, 32'hF00F00FF, 1'b0, 1'b0, 1},
      '{5'd11, 32'hF0F01234, 32'h0FF0FF00, 1'b1, 32'hFFF0FF34, 1'b0, 1'b0, 1},
      '{5'd12, 32'hF0F01234, 32'h0FF0FF00, 1'b1, 32'h00F01200, 1'b0, 1'b0, 1},
      '{5'd13, 32'hF0F01234, 32'h0FF0FF00, 1'b1, 32'h00FF12CB, 1'b0, 1'b0, 1},
      '{5'd14, 32'hF0F01234, 32'h0FF0FF00, 1'b1, 32'hFF00ED34, 1'b0, 1'b0, 1},
      '{5'd15, 32'hF0F01234, 32'h0FF0FF00, 1'b1, 32'hFF0FEDFF, 1'b0, 1'b0, 1}
   };

   vec_t undef_v [3] = '{
      '{5'd0,  32'hFFFF, 32'hFFFF, 1'b1, 32'h0, 1'b0, 1'b1, 1},
      '{5'd19, 32'hFFFF, 32'hFFFF, 1'b1, 32'h0, 1'b0, 1'b1, 1},
      '{5'd31, 32'hFFFF, 32'hFFFF, 1'b1, 32'h0, 1'b0, 1'b1, 1}
   };

   vec_t mul_v [4] = '{
      '{5'd16, 32'h00010000, 32'h00010000, 1'b0, 32'h0,        1'b1, 1'b1, 33},
      '{5'd16, 32'h3,        32'h5,        1'b0, 32'hF,        1'b0, 1'b0, 33},
      '{5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h1,        1'b1, 1'b0, 33},
      '{5'd16, 32'h12345678, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 33}
   };

   vec_t div_v [7] = '{
      '{5'd17, 32'd100,      32'd7,        1'b0, 32'd14,       1'b0, 1'b0, 33},
      '{5'd18, 32'd100,      32'd7,        1'b0, 32'd2,        1'b0, 1'b0, 33},
      '{5'd17, 32'd100,      32'd0,        1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 33},
      '{5'd18, 32'd100,      32'd0,        1'b0, 32'd100,      1'b1, 1'b0, 33},
      '{5'd17, 32'hFFFFFFFF, 32'h1,        1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 33},
      '{5'd18, 32'hFFFFFFFF, 32'h10,       1'b0, 32'hF,        1'b0, 1'b0, 33},
      '{5'd17, 32'hFFFFFFFF, 32'h80000001, 1'b0, 32'h1,        1'b0, 1'b0, 33}
   };

   always #5 clk = ~clk;

   alu_mc #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .Card      (Card),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .F         (F),
      .Cout      (Cout),
      .Zero      (Zero)
   );

   // Present one request at posedge+1; wait (bounded) for out_valid and
   // record latency and outputs. Operand inputs are scrambled after accept.
   task automatic run_op(input logic [4:0] card, input logic [31:0] a,
                         input logic [31:0] b, input logic cin);
      Card     = card;
      A        = a;
      B        = b;
      Cin      = cin;
      in_valid = 1'b1;
      r_ok     = (in_ready === 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      A        = $urandom;
      B        = $urandom;
      Cin      = ~cin;
      Card     = 5'd14;
      r_lat    = 1;
      while (out_valid !== 1'b1 && r_lat < 200) begin
         @(posedge clk); #1;
         r_lat++;
      end
      r_f  = F;
      r_c  = Cout;
      r_z  = Zero;
      r_ok = r_ok & (out_valid === 1'b1);
   endtask

   task automatic test_reset;
      #3;
      checks++;
      if (out_valid !== 1'b0 || F !== 32'h0 || Cout !== 1'b0 || Zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: out_valid=%b F=%h Cout=%b Zero=%b, want 0 00000000 0 0",
                  out_valid, F, Cout, Zero);
      end else $display("ok reset_outputs");
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end else $display("ok reset_release");
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic test_arith;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         run_op(arith_v[i].card, arith_v[i].a, arith_v[i].b, arith_v[i].cin);
         checks++;
         if (r_ok !== 1'b1 || r_lat !== arith_v[i].lat || r_f !== arith_v[i].f ||
             r_c !== arith_v[i].c || r_z !== arith_v[i].z) begin
            errors++;
            $display("FAIL arith[%0d] card=%0d: ok=%b lat=%0d F=%h C=%b Z=%b, want lat=%0d F=%h C=%b Z=%b",
                     i, arith_v[i].card, r_ok, r_lat, r_f, r_c, r_z,
                     arith_v[i].lat, arith_v[i].f, arith_v[i].c, arith_v[i].z);
         end else $display("ok arith[%0d] card=%0d F=%h", i, arith_v[i].card, r_f);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_logic;
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         run_op(logic_v[i].card, logic_v[i].a, logic_v[i].b, logic_v[i].cin);
         checks++;
         if (r_ok !== 1'b1 || r_lat !== logic_v[i].lat || r_f !== logic_v[i].f ||
             r_c !== logic_v[i].c || r_z !== logic_v[i].z) begin
            errors++;
            $display("FAIL logic[%0d] card=%0d: ok=%b lat=%0d F=%h C=%b Z=%b, want lat=%0d F=%h C=%b Z=%b",
                     i, logic_v[i].card, r_ok, r_lat, r_f, r_c, r_z,
                     logic_v[i].lat, logic_v[i].f, logic_v[i].c, logic_v[i].z);
         end else $display("ok logic[%0d] card=%0d F=%h", i, logic_v[i].card, r_f);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_undefined;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         run_op(undef_v[i].card, undef_v[i].a, undef_v[i].b, undef_v[i].cin);
         checks++;
         if (r_ok !== 1'b1 || r_lat !== undef_v[i].lat || r_f !== undef_v[i].f ||
             r_c !== undef_v[i].c || r_z !== undef_v[i].z) begin
            errors++;
            $display("FAIL undef[%0d] card=%0d: ok=%b lat=%0d F=%h C=%b Z=%b, want lat=%0d F=%h C=%b Z=%b",
                     i, undef_v[i].card, r_ok, r_lat, r_f, r_c, r_z,
                     undef_v[i].lat, undef_v[i].f, undef_v[i].c, undef_v[i].z);
         end else $display("ok undef[%0d] card=%0d", i, undef_v[i].card);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mul;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         run_op(mul_v[i].card, mul_v[i].a, mul_v[i].b, mul_v[i].cin);
         checks++;
         if (r_ok !== 1'b1 || r_lat !== mul_v[i].lat || r_f !== mul_v[i].f ||
             r_c !== mul_v[i].c || r_z !== mul_v[i].z) begin
            errors++;
            $display("FAIL mul[%0d]: ok=%b lat=%0d F=%h C=%b Z=%b, want lat=%0d F=%h C=%b Z=%b",
                     i, r_ok, r_lat, r_f, r_c, r_z,
                     mul_v[i].lat, mul_v[i].f, mul_v[i].c, mul_v[i].z);
         end else $display("ok mul[%0d] F=%h C=%b lat=%0d", i, r_f, r_c, r_lat);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_div;
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         run_op(div_v[i].card, div_v[i].a, div_v[i].b, div_v[i].cin);
         checks++;
         if (r_ok !== 1'b1 || r_lat !== div_v[i].lat || r_f !== div_v[i].f ||
             r_c !== div_v[i].c || r_z !== div_v[i].z) begin
            errors++;
            $display("FAIL div[%0d] card=%0d: ok=%b lat=%0d F=%h C=%b Z=%b, want lat=%0d F=%h C=%b Z=%b",
                     i, div_v[i].card, r_ok, r_lat, r_f, r_c, r_z,
                     div_v[i].lat, div_v[i].f, div_v[i].c, div_v[i].z);
         end else $display("ok div[%0d] card=%0d F=%h C=%b", i, div_v[i].card, r_f, r_c);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      run_op(5'd14, 32'hA5, 32'h0F, 1'b0);
      checks++;
      if (r_ok !== 1'b1 || r_f !== 32'hAA || r_c !== 1'b0 || r_z !== 1'b0) begin
         errors++;
         $display("FAIL bp_result: ok=%b F=%h C=%b Z=%b, want F=000000aa C=0 Z=0", r_ok, r_f, r_c, r_z);
      end else $display("ok bp_result F=%h", r_f);
      // hold off the consumer while a new request is offered every cycle
      Card     = 5'd1;
      A        = 32'h1;
      B        = 32'h1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || F !== 32'hAA ||
             Cout !== 1'b0 || Zero !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b F=%h C=%b Z=%b, want 1 0 000000aa 0 0",
                     i, out_valid, in_ready, F, Cout, Zero);
         end else $display("ok bp_hold[%0d]", i);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || F !== 32'hAA) begin
         errors++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b F=%h, want 0 1 000000aa",
                  out_valid, in_ready, F);
      end else $display("ok bp_release");
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || F !== 32'hAA) begin
         errors++;
         $display("FAIL bp_no_accept: out_valid=%b in_ready=%b F=%h, want 0 1 000000aa",
                  out_valid, in_ready, F);
      end else $display("ok bp_no_accept");
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b1;
      run_op(5'd1, 32'h1, 32'h2, 1'b0);
      checks++;
      if (r_ok !== 1'b1 || r_lat !== 1 || r_f !== 32'h3) begin
         errors++;
         $display("FAIL b2b_first: ok=%b lat=%0d F=%h, want lat=1 F=00000003", r_ok, r_lat, r_f);
      end else $display("ok b2b_first F=%h", r_f);
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end else $display("ok b2b_idle");
      run_op(5'd11, 32'h00F0, 32'h0F00, 1'b0);
      checks++;
      if (r_ok !== 1'b1 || r_lat !== 1 || r_f !== 32'h0FF0) begin
         errors++;
         $display("FAIL b2b_second: ok=%b lat=%0d F=%h, want lat=1 F=00000ff0", r_ok, r_lat, r_f);
      end else $display("ok b2b_second F=%h", r_f);
      @(posedge clk); #1;
   endtask

   task automatic test_reset_busy;
      logic saw_valid;
      out_ready = 1'b1;
      Card      = 5'd16;
      A         = 32'h00010000;
      B         = 32'h00010000;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #3;
      checks++;
      if (out_valid !== 1'b0 || F !== 32'h0FF0) begin
         errors++;
         $display("FAIL rb_pre: out_valid=%b F=%h, want 0 00000ff0", out_valid, F);
      end else $display("ok rb_pre");
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || F !== 32'h0 || Cout !== 1'b0 || Zero !== 1'b0) begin
         errors++;
         $display("FAIL rb_async: out_valid=%b F=%h C=%b Z=%b, want 0 00000000 0 0",
                  out_valid, F, Cout, Zero);
      end else $display("ok rb_async");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      saw_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) saw_valid = 1'b1;
      end
      checks++;
      if (saw_valid !== 1'b0 || F !== 32'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rb_discard: saw_valid=%b F=%h in_ready=%b, want 0 00000000 1",
                  saw_valid, F, in_ready);
      end else $display("ok rb_discard");
      run_op(5'd16, 32'h3, 32'h5, 1'b0);
      checks++;
      if (r_ok !== 1'b1 || r_lat !== 33 || r_f !== 32'hF || r_c !== 1'b0 || r_z !== 1'b0) begin
         errors++;
         $display("FAIL rb_after: ok=%b lat=%0d F=%h C=%b Z=%b, want lat=33 F=0000000f C=0 Z=0",
                  r_ok, r_lat, r_f, r_c, r_z);
      end else $display("ok rb_after F=%h lat=%0d", r_f, r_lat);
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_arith();
      test_logic();
      test_undefined();
      test_mul();
      test_div();
      test_backpressure();
      test_back_to_back();
      test_reset_busy();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; legal range 4..64.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  request present on A/B/Cin/Card.
REQ-005 in_ready  output  1  block accepts request this cycle.
REQ-006 A  input  WIDTH  operand A.
REQ-007 B  input  WIDTH  operand B.
REQ-008 Cin  input  1  carry/borrow in.
REQ-009 Card  input  5  operation code.
REQ-010 out_valid  output  1  result valid on F/Cout/Zero.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 F  output  WIDTH  result, registered.
REQ-013 Cout  output  1  carry/flag, registered.
REQ-014 Zero  output  1  1 when F == 0, registered with F.

Function
REQ-015 FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 Accept = in_valid & in_ready; A, B, Cin, Card captured into internal registers at accept; inputs ignored outside accept cycle.
REQ-017 Single-cycle ops (Card 0-15, 19-31): IDLE -> DONE at accept, result registered same edge; out_valid asserted cycle after accept (latency 1).
REQ-018 Card 1 A+B; 2 A+B+Cin; 3 A-B; 4 A-B-Cin; 5 B-A; 6 B-A-Cin; Cout = carry out of WIDTH-bit sum, subtraction X-Y-c computed as X + ~Y + !c (Cout=1 means no borrow).
REQ-019 Card 7 A; 8 B; 9 ~A; 10 ~B; 11 A|B; 12 A&B; 13 ~(A^B); 14 A^B; 15 ~(A&B); Cout = 0.
REQ-020 Card 0 and 19-31 (undefined): F = 0, Cout = 0, Zero = 1.
REQ-021 Card 16 MULU: unsigned shift-add, F = low WIDTH bits of A*B, Cout = 1 iff high WIDTH bits nonzero.
REQ-022 Card 17 DIVU: restoring division, F = A/B unsigned; Card 18 REMU: F = A%B; Cout = 0.
REQ-023 Divide by zero (Cards 17/18, B = 0): quotient F = all ones, remainder F = A, Cout = 1; same latency as normal divide.
REQ-024 Cards 16-18: IDLE -> BUSY at accept; BUSY for exactly WIDTH cycles (one bit per cycle via internal counter); BUSY -> DONE on final iteration; out_valid first asserted WIDTH+1 cycles after accept.
REQ-025 DONE: F, Cout, Zero, out_valid held stable until out_valid & out_ready; then DONE -> IDLE next edge, out_valid deasserts.
REQ-026 Minimum request spacing: 2 cycles for single-cycle ops with out_ready held 1; no overlap of requests.
REQ-027 F, Cout, Zero retain last result after handshake until next result is written.
REQ-028 Zero computed from the WIDTH-bit F value being registered, never from the wider internal product.

Reset
REQ-029 rst_n low at any time, including in BUSY or DONE: state -> IDLE immediately, iteration counter 0, F = 0, Cout = 0, Zero = 0, out_valid = 0; in operation discarded.
REQ-030 in_ready = 1 once rst_n is high and state is IDLE; first accept possible on the first rising edge after deassertion.

Verification (WIDTH = 32)
REQ-031 Card=1, A=0x10, B=0x08, Cin=1, out_ready=1 -> one cycle later out_valid=1, F=0x18, Cout=0, Zero=0; Card=2 same operands -> F=0x19.
REQ-032 Card=2, A=0xFFFFFFFF, B=0, Cin=1 -> F=0, Cout=1, Zero=1; Card=3, A=0x8, B=0x10 -> F=0xFFFFFFF8, Cout=0.
REQ-033 Card=16, A=B=0x00010000 -> out_valid exactly 33 cycles after accept, F=0, Cout=1, Zero=1; A=3, B=5 -> F=15, Cout=0.
REQ-034 Card=17, A=100, B=7 -> F=14; Card=18 -> F=2; Card=17, B=0 -> F=0xFFFFFFFF, Cout=1; Card=18, B=0 -> F=100, Cout=1.
REQ-035 out_ready=0 for 5 cycles in DONE -> F/Cout/Zero/out_valid stable, in_ready=0, new in_valid not accepted; out_ready=1 -> IDLE next cycle.
REQ-036 rst_n pulsed low at BUSY cycle 10 of Card=16 -> outputs zero asynchronously, no out_valid; next request after release completes normally.
